exec_unit_cluster: RTL and testbench
====================================

Name: exec_unit_cluster

Overview:
- Execute stage of the Tomasulo core: one single-cycle ALU and one two-cycle load/store (LS) unit with a private data memory.
- Receives issued operations from reservation_stations.
- Returns one result per cycle to rob_module on a shared writeback port.
- Reports condition evaluation and branch misprediction.

Parameters:
GPR_SIZE, 64, operand/result width
ROB_IDX_SIZE, 3, ROB tag width
MEM_WORDS, 64, LS memory depth in 64-bit words

Ports:
in_clk  in  1  clock, all state updates on rising edge
in_rst  in  1  synchronous active-high reset
in_rs_alu_start  in  1  ALU issue strobe
in_rs_alu_op  in  4  ALU opcode
in_rs_alu_val_a  in  GPR_SIZE  operand A
in_rs_alu_val_b  in  GPR_SIZE  operand B
in_rs_alu_dst_rob_index  in  ROB_IDX_SIZE  result tag
in_rs_alu_set_nzcv  in  1  op writes flags
in_rs_alu_nzcv  in  4  current flags {N,Z,C,V}
in_rs_alu_cond_codes  in  4  ARM condition code
in_rs_ls_start  in  1  LS issue strobe
in_rs_ls_op  in  4  LS opcode
in_rs_ls_val_a  in  GPR_SIZE  base address
in_rs_ls_val_b  in  GPR_SIZE  offset (load) / store data
in_rs_ls_dst_rob_index  in  ROB_IDX_SIZE  result tag
out_rs_alu_ready  out  1  ALU accepts issue
out_rs_ls_ready  out  1  LS accepts issue
out_rob_done  out  1  writeback valid
out_rob_dst_rob_index  out  ROB_IDX_SIZE  writeback tag
out_rob_value  out  GPR_SIZE  writeback value
out_rob_set_nzcv  out  1  writeback carries flags
out_rob_nzcv  out  4  new flags
out_rob_is_mispred  out  1  branch mispredicted
out_alu_condition  out  1  evaluated condition of the op being written back

Behaviour:
- Reset (in_rst=1 at an edge):
  - All outputs 0 except both ready signals, which are 0 during reset and 1 on the first cycle after reset.
  - Clears the LS pipeline and pending buffer.
  - Zeroes memory.
  - Reset mid-operation discards in-flight ops.
- ALU opcodes:
  - 0 ADD a+b; 1 SUB a-b; 2 AND; 3 ORR; 4 EOR; 5 ORN a|~b.
  - 6 LSL a<<b[5:0]; 7 LSR; 8 ASR.
  - 9 CSEL cond?a:b; 10 CSINC cond?a:b+1; 11 CSINV cond?a:~b; 12 CSNEG cond?a:-b.
  - 13 MOV b; 14 BCOND value 0; 15 NOP value 0.
  - Arithmetic is modulo 2^64.
- Condition evaluation uses standard ARM semantics on in_rs_alu_nzcv:
  - EQ0 NE1 CS2 CC3 MI4 PL5 VS6 VC7 HI8 LS9 GE10 LT11 GT12 LE13 AL14 NV15.
  - NV evaluates true.
- Flags:
  - When set_nzcv=1, out_rob_set_nzcv=1.
  - N=result[63]; Z=(result==0).
  - ADD: C=carry out, V=signed overflow.
  - SUB: C=NOT borrow (a>=b unsigned), V=signed overflow.
  - All other ops: C=V=0.
  - When set_nzcv=0, out_rob_nzcv=0.
- ALU latency: 1 cycle. Result is registered and presented with out_rob_done=1 for exactly one cycle on the edge after start.
- out_rs_alu_ready is always 1 outside reset; the ALU accepts back-to-back issues every cycle.
- Misprediction:
  - out_rob_is_mispred=1 only for BCOND when the condition is true (predict-not-taken).
  - Otherwise 0.
  - out_alu_condition=0 for LS writebacks.
- LS opcodes:
  - 0 LOAD: address = a+b; value = mem[address[8:3]].
  - 1 STORE: mem[a[8:3]] <= b; writeback value 0.
  - Other opcodes: writeback value 0, no memory write.
  - Address bits [2:0] ignored; higher bits wrap modulo MEM_WORDS.
- LS latency: 2 cycles from start to writeback.
  - out_rs_ls_ready=0 from the cycle after accept until its result is written back.
  - start while ready=0 is ignored.
- LS writebacks never set flags.
- Writeback arbitration:
  - ALU has priority.
  - If ALU and LS results complete in the same cycle, LS result is held in a one-entry pending buffer and written back on the next cycle without an ALU result.
  - ls_ready stays 0 while pending.
- Store-then-load to the same address issued in consecutive LS slots returns the stored value.

Test Plan:
- Reset held 2 cycles, then released -> all outputs 0 during reset; alu_ready=1, ls_ready=1 one cycle after release.
- ALU ADD a=0x7FFF_FFFF_FFFF_FFFF, b=1, set_nzcv=1, tag 5 -> next cycle done=1, tag 5, value 0x8000_0000_0000_0000, nzcv=1001.
- SUB a=3 b=3 set_nzcv=1 -> value 0, nzcv=0110; CSEL cond EQ, nzcv=0100, a=7 b=9 -> value 7, out_alu_condition=1.
- BCOND cond NE with nzcv=0000 -> done=1, value 0, is_mispred=1; with nzcv=0100 -> is_mispred=0.
- STORE a=0x40 b=0xDEAD, then LOAD a=0x38 b=8 -> store writeback value 0 at +2 cycles; load returns 0xDEAD at +2 cycles; ls_ready low while busy.
- ALU op and LS result completing in the same cycle -> ALU written back first, LS result the following cycle with correct tag; done never asserted for two results at once.

Source files
------------

// File: rtl/exec_unit_cluster.sv
// Execute stage: single-cycle ALU plus two-cycle load/store unit with a private
// data memory, sharing one writeback port to the ROB (ALU has priority).
module exec_unit_cluster #(
    parameter int GPR_SIZE     = 64,
    parameter int ROB_IDX_SIZE = 3,
    parameter int MEM_WORDS    = 64
) (
    input  logic                    in_clk,
    input  logic                    in_rst,
    input  logic                    in_rs_alu_start,
    input  logic [3:0]              in_rs_alu_op,
    input  logic [GPR_SIZE-1:0]     in_rs_alu_val_a,
    input  logic [GPR_SIZE-1:0]     in_rs_alu_val_b,
    input  logic [ROB_IDX_SIZE-1:0] in_rs_alu_dst_rob_index,
    input  logic                    in_rs_alu_set_nzcv,
    input  logic [3:0]              in_rs_alu_nzcv,
    input  logic [3:0]              in_rs_alu_cond_codes,
    input  logic                    in_rs_ls_start,
    input  logic [3:0]              in_rs_ls_op,
    input  logic [GPR_SIZE-1:0]     in_rs_ls_val_a,
    input  logic [GPR_SIZE-1:0]     in_rs_ls_val_b,
    input  logic [ROB_IDX_SIZE-1:0] in_rs_ls_dst_rob_index,
    output logic                    out_rs_alu_ready,
    output logic                    out_rs_ls_ready,
    output logic                    out_rob_done,
    output logic [ROB_IDX_SIZE-1:0] out_rob_dst_rob_index,
    output logic [GPR_SIZE-1:0]     out_rob_value,
    output logic                    out_rob_set_nzcv,
    output logic [3:0]              out_rob_nzcv,
    output logic                    out_rob_is_mispred,
    output logic                    out_alu_condition
);

    localparam int AW = $clog2(MEM_WORDS);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_ORR   = 4'd3;
    localparam logic [3:0] OP_EOR   = 4'd4;
    localparam logic [3:0] OP_ORN   = 4'd5;
    localparam logic [3:0] OP_LSL   = 4'd6;
    localparam logic [3:0] OP_LSR   = 4'd7;
    localparam logic [3:0] OP_ASR   = 4'd8;
    localparam logic [3:0] OP_CSEL  = 4'd9;
    localparam logic [3:0] OP_CSINC = 4'd10;
    localparam logic [3:0] OP_CSINV = 4'd11;
    localparam logic [3:0] OP_CSNEG = 4'd12;
    localparam logic [3:0] OP_MOV   = 4'd13;
    localparam logic [3:0] OP_BCOND = 4'd14;

    localparam logic [3:0] LS_LOAD  = 4'd0;
    localparam logic [3:0] LS_STORE = 4'd1;

    logic [GPR_SIZE-1:0] mem [MEM_WORDS];

    // ---------------- condition evaluation ----------------
    logic flag_n, flag_z, flag_c, flag_v;
    logic cond_base, cond;

    assign {flag_n, flag_z, flag_c, flag_v} = in_rs_alu_nzcv;

    always_comb begin
        cond_base = 1'b1;
        case (in_rs_alu_cond_codes[3:1])
            3'd0: cond_base = flag_z;
            3'd1: cond_base = flag_c;
            3'd2: cond_base = flag_n;
            3'd3: cond_base = flag_v;
            3'd4: cond_base = flag_c & ~flag_z;
            3'd5: cond_base = (flag_n == flag_v);
            3'd6: cond_base = (flag_n == flag_v) & ~flag_z;
            default: cond_base = 1'b1;
        endcase
        // odd codes invert, except NV which behaves like AL
        cond = cond_base;
        if (in_rs_alu_cond_codes[0] && (in_rs_alu_cond_codes != 4'd15))
            cond = ~cond_base;
    end

    // ---------------- ALU datapath ----------------
    logic [GPR_SIZE-1:0] a, b, alu_val;
    logic [GPR_SIZE:0]   add_full;
    logic [5:0]          shamt;
    logic                alu_c, alu_v;
    logic [3:0]          alu_nzcv;

    assign a        = in_rs_alu_val_a;
    assign b        = in_rs_alu_val_b;
    assign shamt    = b[5:0];
    assign add_full = {1'b0, a} + {1'b0, b};

    always_comb begin
        alu_val = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (in_rs_alu_op)
            OP_ADD: begin
                alu_val = add_full[GPR_SIZE-1:0];
                alu_c   = add_full[GPR_SIZE];
                alu_v   = (a[GPR_SIZE-1] == b[GPR_SIZE-1]) &&
                          (alu_val[GPR_SIZE-1] != a[GPR_SIZE-1]);
            end
            OP_SUB: begin
                alu_val = a - b;
                alu_c   = (a >= b);
                alu_v   = (a[GPR_SIZE-1] != b[GPR_SIZE-1]) &&
                          (alu_val[GPR_SIZE-1] != a[GPR_SIZE-1]);
            end
            OP_AND:   alu_val = a & b;
            OP_ORR:   alu_val = a | b;
            OP_EOR:   alu_val = a ^ b;
            OP_ORN:   alu_val = a | ~b;
            OP_LSL:   alu_val = a << shamt;
            OP_LSR:   alu_val = a >> shamt;
            OP_ASR:   alu_val = GPR_SIZE'($signed(a) >>> shamt);
            OP_CSEL:  alu_val = cond ? a : b;
            OP_CSINC: alu_val = cond ? a : b + GPR_SIZE'(1);
            OP_CSINV: alu_val = cond ? a : ~b;
            OP_CSNEG: alu_val = cond ? a : '0 - b;
            OP_MOV:   alu_val = b;
            default:  alu_val = '0;
        endcase
    end

    assign alu_nzcv = in_rs_alu_set_nzcv ?
                      {alu_val[GPR_SIZE-1], (alu_val == '0), alu_c, alu_v} : 4'b0000;

    // ---------------- LS unit ----------------
    logic                    s1_valid;
    logic [3:0]              s1_op;
    logic [AW-1:0]           s1_idx;
    logic [GPR_SIZE-1:0]     s1_data;
    logic [ROB_IDX_SIZE-1:0] s1_tag;
    logic [GPR_SIZE-1:0]     ls_sum, ls_res;
    logic [AW-1:0]           ls_idx;
    logic                    ls_accept;

    logic                    pend_valid;
    logic [ROB_IDX_SIZE-1:0] pend_tag;
    logic [GPR_SIZE-1:0]     pend_value;
    logic                    wb_is_ls;
    logic                    ready_en;

    assign ls_sum = in_rs_ls_val_a + in_rs_ls_val_b;
    assign ls_idx = (in_rs_ls_op == LS_STORE) ? in_rs_ls_val_a[3 +: AW] : ls_sum[3 +: AW];
    assign ls_res = (s1_op == LS_LOAD) ? mem[s1_idx] : '0;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{ls_sum[GPR_SIZE-1:3+AW], ls_sum[2:0]};

    // busy covers the execute cycle, any pending hold and the writeback cycle itself
    assign out_rs_alu_ready = ready_en;
    assign out_rs_ls_ready  = ready_en & ~s1_valid & ~pend_valid & ~wb_is_ls;
    assign ls_accept        = in_rs_ls_start & out_rs_ls_ready;

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            ready_en              <= 1'b0;
            s1_valid              <= 1'b0;
            s1_op                 <= '0;
            s1_idx                <= '0;
            s1_data               <= '0;
            s1_tag                <= '0;
            pend_valid            <= 1'b0;
            pend_tag              <= '0;
            pend_value            <= '0;
            wb_is_ls              <= 1'b0;
            out_rob_done          <= 1'b0;
            out_rob_dst_rob_index <= '0;
            out_rob_value         <= '0;
            out_rob_set_nzcv      <= 1'b0;
            out_rob_nzcv          <= '0;
            out_rob_is_mispred    <= 1'b0;
            out_alu_condition     <= 1'b0;
            for (int unsigned i = 0; i < MEM_WORDS; i++)
                mem[i] <= '0;
        end else begin
            ready_en <= 1'b1;
            s1_valid <= ls_accept;
            if (ls_accept) begin
                s1_op   <= in_rs_ls_op;
                s1_idx  <= ls_idx;
                s1_data <= in_rs_ls_val_b;
                s1_tag  <= in_rs_ls_dst_rob_index;
            end
            if (s1_valid && (s1_op == LS_STORE))
                mem[s1_idx] <= s1_data;

            // an ALU result displaces a completing LS result into the pending slot
            if (in_rs_alu_start) begin
                if (s1_valid) begin
                    pend_valid <= 1'b1;
                    pend_tag   <= s1_tag;
                    pend_value <= ls_res;
                end
            end else begin
                pend_valid <= 1'b0;
            end

            if (in_rs_alu_start) begin
                wb_is_ls              <= 1'b0;
                out_rob_done          <= 1'b1;
                out_rob_dst_rob_index <= in_rs_alu_dst_rob_index;
                out_rob_value         <= alu_val;
                out_rob_set_nzcv      <= in_rs_alu_set_nzcv;
                out_rob_nzcv          <= alu_nzcv;
                out_rob_is_mispred    <= (in_rs_alu_op == OP_BCOND) && cond;
                out_alu_condition     <= cond;
            end else if (pend_valid || s1_valid) begin
                wb_is_ls              <= 1'b1;
                out_rob_done          <= 1'b1;
                out_rob_dst_rob_index <= pend_valid ? pend_tag : s1_tag;
                out_rob_value         <= pend_valid ? pend_value : ls_res;
                out_rob_set_nzcv      <= 1'b0;
                out_rob_nzcv          <= '0;
                out_rob_is_mispred    <= 1'b0;
                out_alu_condition     <= 1'b0;
            end else begin
                wb_is_ls              <= 1'b0;
                out_rob_done          <= 1'b0;
                out_rob_dst_rob_index <= '0;
                out_rob_value         <= '0;
                out_rob_set_nzcv      <= 1'b0;
                out_rob_nzcv          <= '0;
                out_rob_is_mispred    <= 1'b0;
                out_alu_condition     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_exec_unit_cluster.sv
// Randomized self-checking bench for exec_unit_cluster against a transaction-level
// model of the ALU, condition codes, LS memory and writeback arbitration.
module tb_exec_unit_cluster;

    logic        clk = 1'b0;
    logic        in_rst;
    logic        alu_start, alu_setn, ls_start;
    logic [3:0]  alu_op, alu_nz, alu_cc, ls_op;
    logic [63:0] alu_a, alu_b, ls_a, ls_b;
    logic [2:0]  alu_tag, ls_tag;

    logic        alu_ready, ls_ready, done, setn_o, mispred, cond_o;
    logic [2:0]  tag_o;
    logic [63:0] value_o;
    logic [3:0]  nzcv_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    exec_unit_cluster #(.GPR_SIZE(64), .ROB_IDX_SIZE(3), .MEM_WORDS(64)) dut (
        .in_clk                  (clk),
        .in_rst                  (in_rst),
        .in_rs_alu_start         (alu_start),
        .in_rs_alu_op            (alu_op),
        .in_rs_alu_val_a         (alu_a),
        .in_rs_alu_val_b         (alu_b),
        .in_rs_alu_dst_rob_index (alu_tag),
        .in_rs_alu_set_nzcv      (alu_setn),
        .in_rs_alu_nzcv          (alu_nz),
        .in_rs_alu_cond_codes    (alu_cc),
        .in_rs_ls_start          (ls_start),
        .in_rs_ls_op             (ls_op),
        .in_rs_ls_val_a          (ls_a),
        .in_rs_ls_val_b          (ls_b),
        .in_rs_ls_dst_rob_index  (ls_tag),
        .out_rs_alu_ready        (alu_ready),
        .out_rs_ls_ready         (ls_ready),
        .out_rob_done            (done),
        .out_rob_dst_rob_index   (tag_o),
        .out_rob_value           (value_o),
        .out_rob_set_nzcv        (setn_o),
        .out_rob_nzcv            (nzcv_o),
        .out_rob_is_mispred      (mispred),
        .out_alu_condition       (cond_o)
    );

    // reference model state
    logic [63:0] m_mem [64];
    bit          m_ls_valid;
    int          m_ls_due;
    logic [2:0]  m_ls_tag;
    logic [63:0] m_ls_val;
    bit          m_ls_ready;
    int          edge_n = 0;

    logic        e_done, e_setn, e_mis, e_cond, e_alu_rdy, e_ls_rdy;
    logic [2:0]  e_tag;
    logic [63:0] e_val;
    logic [3:0]  e_nzcv;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at edge %0d: got 0x%0h expected 0x%0h", tag, edge_n, got, exp);
        end
    endtask

    function automatic bit cond_ok(input logic [3:0] f, input logic [3:0] cc);
        bit n, z, c, v;
        {n, z, c, v} = f;
        case (cc)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return c;
            4'd3:  return !c;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return c && !z;
            4'd9:  return !c || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    task automatic alu_ref(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                           input logic [3:0] fl, input logic [3:0] cc, input logic setn,
                           output logic [63:0] r, output logic [3:0] nz, output logic cnd);
        logic [64:0] u, s;
        logic [5:0]  sh;
        logic        c, v;
        cnd = cond_ok(fl, cc);
        c = 1'b0; v = 1'b0;
        sh = b[5:0];
        case (op)
            4'd0: begin
                u = {1'b0, a} + {1'b0, b}; r = u[63:0]; c = u[64];
                s = {a[63], a} + {b[63], b}; v = s[64] ^ s[63];
            end
            4'd1: begin
                r = a - b; c = (a >= b);
                s = {a[63], a} - {b[63], b}; v = s[64] ^ s[63];
            end
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a ^ b;
            4'd5:  r = a | ~b;
            4'd6:  r = a << sh;
            4'd7:  r = a >> sh;
            4'd8:  r = a[63] ? ~((~a) >> sh) : (a >> sh);
            4'd9:  r = cnd ? a : b;
            4'd10: r = cnd ? a : b + 64'd1;
            4'd11: r = cnd ? a : ~b;
            4'd12: r = cnd ? a : (~b) + 64'd1;
            4'd13: r = b;
            default: r = 64'd0;
        endcase
        nz = setn ? {r[63], (r == 64'd0), c, v} : 4'd0;
    endtask

    task automatic model_edge();
        logic [63:0] r, addr;
        logic [3:0]  nz;
        logic        cnd;
        bit          ls_out;
        {e_done, e_setn, e_mis, e_cond, e_tag, e_val, e_nzcv} = '0;
        ls_out = 1'b0;
        if (in_rst) begin
            m_ls_valid = 1'b0;
            m_ls_ready = 1'b0;
            e_alu_rdy  = 1'b0;
            for (int i = 0; i < 64; i++) m_mem[i] = 64'd0;
        end else begin
            if (alu_start) begin
                alu_ref(alu_op, alu_a, alu_b, alu_nz, alu_cc, alu_setn, r, nz, cnd);
                e_done = 1'b1; e_tag = alu_tag; e_val = r; e_setn = alu_setn;
                e_nzcv = nz; e_cond = cnd; e_mis = (alu_op == 4'd14) && cnd;
            end else if (m_ls_valid && edge_n >= m_ls_due) begin
                e_done = 1'b1; e_tag = m_ls_tag; e_val = m_ls_val;
                m_ls_valid = 1'b0;
                ls_out = 1'b1;
            end
            if (ls_start && m_ls_ready) begin
                m_ls_val = 64'd0;
                if (ls_op == 4'd0) begin
                    addr = ls_a + ls_b;
                    m_ls_val = m_mem[addr[8:3]];
                end else if (ls_op == 4'd1) begin
                    m_mem[ls_a[8:3]] = ls_b;
                end
                m_ls_valid = 1'b1;
                m_ls_due   = edge_n + 1;
                m_ls_tag   = ls_tag;
            end
            m_ls_ready = !m_ls_valid && !ls_out;
            e_alu_rdy  = 1'b1;
        end
        e_ls_rdy = m_ls_ready;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_eq("done", done, e_done);
        check_eq("tag", tag_o, e_tag);
        check_eq("value", value_o, e_val);
        check_eq("set_nzcv", setn_o, e_setn);
        check_eq("nzcv", nzcv_o, e_nzcv);
        check_eq("mispred", mispred, e_mis);
        check_eq("condition", cond_o, e_cond);
        check_eq("alu_ready", alu_ready, e_alu_rdy);
        check_eq("ls_ready", ls_ready, e_ls_rdy);
        edge_n++;
    endtask

    task automatic alu_issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                             input logic [2:0] tag, input logic setn, input logic [3:0] nz,
                             input logic [3:0] cc);
        alu_start = 1'b1; alu_op = op; alu_a = a; alu_b = b;
        alu_tag = tag; alu_setn = setn; alu_nz = nz; alu_cc = cc;
    endtask

    task automatic ls_issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                            input logic [2:0] tag);
        ls_start = 1'b1; ls_op = op; ls_a = a; ls_b = b; ls_tag = tag;
    endtask

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 3))
            0: return {$urandom, $urandom};
            1: return 64'($urandom_range(0, 8));
            2: return {1'b0, 63'h7FFF_FFFF_FFFF_FFFF} - 64'($urandom_range(0, 2));
            default: return {32'hFFFF_FFFF, $urandom};
        endcase
    endfunction

    initial begin
        {alu_start, alu_setn, ls_start, alu_op, alu_nz, alu_cc, ls_op} = '0;
        {alu_a, alu_b, ls_a, ls_b, alu_tag, ls_tag} = '0;
        for (int i = 0; i < 64; i++) m_mem[i] = 64'd0;
        m_ls_valid = 1'b0; m_ls_ready = 1'b0; m_ls_due = 0;
        m_ls_tag = '0; m_ls_val = '0;

        in_rst = 1'b1;
        tick(); tick();
        in_rst = 1'b0;
        tick();

        alu_issue(4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 3'd5, 1'b1, 4'b0000, 4'd14);
        tick();
        check_eq("add_const_value", value_o, 64'h8000_0000_0000_0000);
        check_eq("add_const_nzcv", nzcv_o, 4'b1001);
        alu_issue(4'd1, 64'd3, 64'd3, 3'd1, 1'b1, 4'b0000, 4'd14);
        tick();
        check_eq("sub_const_nzcv", nzcv_o, 4'b0110);
        alu_issue(4'd9, 64'd7, 64'd9, 3'd2, 1'b0, 4'b0100, 4'd0);
        tick();
        check_eq("csel_const_value", value_o, 64'd7);
        alu_issue(4'd14, 64'd0, 64'd0, 3'd3, 1'b0, 4'b0000, 4'd1);
        tick();
        check_eq("bcond_taken_mispred", mispred, 1'b1);
        alu_issue(4'd14, 64'd0, 64'd0, 3'd3, 1'b0, 4'b0100, 4'd1);
        tick();
        check_eq("bcond_not_taken_mispred", mispred, 1'b0);
        alu_start = 1'b0;

        ls_issue(4'd1, 64'h40, 64'hDEAD, 3'd4);
        tick();
        ls_start = 1'b0;
        tick(); tick();
        ls_issue(4'd0, 64'h38, 64'd8, 3'd6);
        tick();
        ls_start = 1'b0;
        tick();
        check_eq("load_const_value", value_o, 64'hDEAD);
        tick();

        ls_issue(4'd0, 64'h40, 64'd0, 3'd7);
        tick();
        ls_start = 1'b0;
        alu_issue(4'd13, 64'd0, 64'h55, 3'd2, 1'b0, 4'b0000, 4'd14);
        tick();
        check_eq("collide_alu_tag", tag_o, 3'd2);
        alu_start = 1'b0;
        tick();
        check_eq("collide_ls_tag", tag_o, 3'd7);
        tick();

        for (int n = 0; n < 600; n++) begin
            alu_start = ($urandom_range(0, 1) == 1);
            alu_op    = 4'($urandom_range(0, 15));
            alu_a     = rnd64();
            alu_b     = rnd64();
            alu_tag   = 3'($urandom_range(0, 7));
            alu_setn  = ($urandom_range(0, 1) == 1);
            alu_nz    = 4'($urandom_range(0, 15));
            alu_cc    = 4'($urandom_range(0, 15));
            ls_start  = ($urandom_range(0, 1) == 1);
            ls_op     = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(2, 15))
                                                    : 4'($urandom_range(0, 1));
            ls_a      = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom}
                                                    : 64'($urandom_range(0, 700));
            ls_b      = (ls_op == 4'd1) ? {$urandom, $urandom} : 64'($urandom_range(0, 64));
            ls_tag    = 3'($urandom_range(0, 7));
            tick();
        end

        alu_start = 1'b0; ls_start = 1'b0;
        tick(); tick(); tick(); tick();
        ls_issue(4'd1, 64'h40, 64'h1234, 3'd1);
        tick();
        ls_start = 1'b0;
        in_rst = 1'b1;
        tick(); tick();
        in_rst = 1'b0;
        tick();
        ls_issue(4'd0, 64'h40, 64'd0, 3'd2);
        tick();
        ls_start = 1'b0;
        tick();
        check_eq("load_after_reset", value_o, 64'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
